reg_dump_sequencer: RTL and testbench

REG_DUMP_SEQUENCER -- requirements
Module: reg_dump_sequencer

---
 rtl/reg_dump_sequencer.sv | 117 +++++++++++
 tb/tb_reg_dump_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// Register-file dump sequencer: freezes the pipeline, reads each register and streams it LSB first.
// Optional macro REG_DUMP_PC_EN appends the 4-byte PC after the last register.
module reg_dump_sequencer #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_req,
    input  logic [31:0] regDebug_data,
    input  logic [31:0] pc_value,
    input  logic        tx_ready,
    output logic        Debug_on,
    output logic        stop_debug,
    output logic [4:0]  Debug_read_reg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        dump_done
);

    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

`ifdef REG_DUMP_PC_EN
    typedef enum logic [2:0] {IDLE, HALT, ADDR, LATCH, SEND, DONE, PCLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, HALT, ADDR, LATCH, SEND, DONE} state_t;

    logic unusedPc;
    assign unusedPc = ^pc_value;
`endif

    state_t      state, stateNext;
    logic [4:0]  regIdx, regIdxNext;
    logic [1:0]  byteCnt, byteCntNext;
    logic [31:0] shift, shiftNext;

    // Index and outgoing byte come straight from their state flops, so they stay registered.
    assign Debug_read_reg = regIdx;
    assign tx_data        = shift[7:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        stateNext   = state;
        regIdxNext  = regIdx;
        byteCntNext = byteCnt;
        shiftNext   = shift;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    stateNext  = HALT;
                    regIdxNext = '0;
                end
            end
            HALT:  stateNext = ADDR;
            ADDR:  stateNext = LATCH;
            LATCH: begin
                shiftNext   = regDebug_data;
                byteCntNext = '0;
                stateNext   = SEND;
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    shiftNext   = {8'h00, shift[31:8]};
                    byteCntNext = byteCnt + 2'd1;
                    if (byteCnt == 2'd3) begin
                        if (regIdx != LastIdx) begin
                            regIdxNext = regIdx + 5'd1;
                            stateNext  = ADDR;
                        end else begin
`ifdef REG_DUMP_PC_EN
                            stateNext = PCLD;
`else
                            stateNext = DONE;
`endif
                        end
                    end
                end
            end
`ifdef REG_DUMP_PC_EN
            PCLD: begin
                shiftNext   = pc_value;
                byteCntNext = '0;
                stateNext   = SEND;
            end
`endif
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are flops aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            regIdx     <= '0;
            byteCnt    <= '0;
            shift      <= '0;
            busy       <= 1'b0;
            stop_debug <= 1'b0;
            Debug_on   <= 1'b0;
            tx_valid   <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= stateNext;
            regIdx     <= regIdxNext;
            byteCnt    <= byteCntNext;
            shift      <= shiftNext;
            busy       <= (stateNext != IDLE);
            stop_debug <= (stateNext != IDLE);
            Debug_on   <= (stateNext != IDLE);
            tx_valid   <= (stateNext == SEND);
            dump_done  <= (stateNext == DONE);
        end
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: random register contents and tx_ready patterns
// compared against a byte-stream model built from the register array.
module tb_reg_dump_sequencer;

    localparam int NumRegs = 32;
`ifdef REG_DUMP_PC_EN
    localparam int PcBytes  = 4;
    localparam int PcCycles = 5;
`else
    localparam int PcBytes  = 0;
    localparam int PcCycles = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_req;
    logic        tx_ready;
    logic [31:0] pc_value;
    logic [31:0] regDebug_data;
    logic        Debug_on, stop_debug, tx_valid, busy, dump_done;
    logic [4:0]  Debug_read_reg;
    logic [7:0]  tx_data;

    logic        dumpReq1, txReady1;
    logic [31:0] regData1;
    logic        dbgOn1, stopDbg1, txValid1, busy1, done1;
    logic [4:0]  readReg1;
    logic [7:0]  txData1;

    logic [31:0] regFile [NumRegs];
    logic [7:0]  expBytes[$];
    logic [7:0]  gotBytes[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural register file read port.
    assign regDebug_data = regFile[Debug_read_reg];
    assign regData1      = regFile[readReg1];

    reg_dump_sequencer #(.NUM_REGS(NumRegs)) dut (
        .clk(clk), .rst(rst), .dump_req(dump_req), .regDebug_data(regDebug_data),
        .pc_value(pc_value), .tx_ready(tx_ready), .Debug_on(Debug_on), .stop_debug(stop_debug),
        .Debug_read_reg(Debug_read_reg), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
        .dump_done(dump_done)
    );

    reg_dump_sequencer #(.NUM_REGS(1)) dut1 (
        .clk(clk), .rst(rst), .dump_req(dumpReq1), .regDebug_data(regData1),
        .pc_value(pc_value), .tx_ready(txReady1), .Debug_on(dbgOn1), .stop_debug(stopDbg1),
        .Debug_read_reg(readReg1), .tx_data(txData1), .tx_valid(txValid1), .busy(busy1),
        .dump_done(done1)
    );

    function automatic void build_expected(input int nRegs);
        expBytes.delete();
        for (int k = 0; k < nRegs; k++)
            for (int b = 0; b < 4; b++) expBytes.push_back(regFile[k][8*b +: 8]);
`ifdef REG_DUMP_PC_EN
        for (int b = 0; b < 4; b++) expBytes.push_back(pc_value[8*b +: 8]);
`endif
    endfunction

    task automatic randomize_regs();
        for (int k = 0; k < NumRegs; k++) regFile[k] = $urandom;
    endtask

    // mode 0: tx_ready always 1; mode 1: random tx_ready; mode 2: 10-cycle stall mid-word of register 1.
    // reqAt >= 0 pulses dump_req after that many bytes; rstAt >= 0 asserts rst while that byte index is offered.
    task automatic run_dump(input string name, input int mode, input int reqAt, input int rstAt);
        int cycles = 0, dones = 0, stallLeft = 0, stableErr = 0, flagErr = 0, badIdx = -1;
        bit reqPulsed = 0, stalled = 0, prevStall = 0, aborted = 0;
        logic [7:0] prevData = '0;
        build_expected(NumRegs);
        gotBytes.delete();
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || stop_debug !== 1'b1 || Debug_on !== 1'b1) begin
            failures++;
            $display("FAIL %s_start busy=%b stop_debug=%b Debug_on=%b required 1/1/1", name, busy, stop_debug, Debug_on);
        end
        while (busy === 1'b1 && cycles < 20000) begin
            dump_req = 1'b0;
            cycles++;
            if (dump_done === 1'b1) dones++;
            if (stop_debug !== 1'b1 || Debug_on !== 1'b1) flagErr++;
            if (prevStall && (tx_valid !== 1'b1 || tx_data !== prevData)) stableErr++;
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 99) < 60);
                default: begin
                    if (!stalled && tx_valid === 1'b1 && gotBytes.size() == 6) begin
                        stalled   = 1;
                        stallLeft = 10;
                    end
                    tx_ready = (stallLeft == 0);
                    if (stallLeft > 0) stallLeft--;
                end
            endcase
            prevStall = (tx_valid === 1'b1) && !tx_ready;
            prevData  = tx_data;
            if (rstAt >= 0 && tx_valid === 1'b1 && gotBytes.size() == rstAt) begin
                rst = 1'b1;
                aborted = 1;
                break;
            end
            if (tx_valid === 1'b1 && tx_ready) gotBytes.push_back(tx_data);
            if (reqAt >= 0 && !reqPulsed && gotBytes.size() == reqAt) begin
                dump_req  = 1'b1;
                reqPulsed = 1;
            end
            @(negedge clk);
        end
        if (aborted) begin
            @(negedge clk);
            checks++;
            if ({Debug_on, stop_debug, tx_valid, busy, dump_done, Debug_read_reg, tx_data} !== '0) begin
                failures++;
                $display("FAIL %s_abort_outputs on=%b stop=%b valid=%b busy=%b done=%b idx=%0d data=%h required all 0",
                         name, Debug_on, stop_debug, tx_valid, busy, dump_done, Debug_read_reg, tx_data);
            end
            rst = 1'b0;
            flagErr = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (tx_valid !== 1'b0 || busy !== 1'b0) flagErr++;
            end
            checks++;
            if (flagErr != 0) begin
                failures++;
                $display("FAIL %s_after_abort activity_cycles=%0d required 0", name, flagErr);
            end
            return;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy=%b after %0d cycles required 0", name, busy, cycles);
        end
        checks++;
        if (gotBytes.size() != expBytes.size()) begin
            failures++;
            $display("FAIL %s_byte_count got=%0d required=%0d", name, gotBytes.size(), expBytes.size());
        end
        for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++)
            if (badIdx < 0 && gotBytes[i] !== expBytes[i]) badIdx = i;
        checks++;
        if (badIdx >= 0) begin
            failures++;
            $display("FAIL %s_stream byte %0d got=%h required=%h", name, badIdx, gotBytes[badIdx], expBytes[badIdx]);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s_dump_done pulses=%0d required=1", name, dones);
        end
        checks++;
        if (flagErr != 0 || stableErr != 0) begin
            failures++;
            $display("FAIL %s_flags freeze_drops=%0d unstable_stalls=%0d required 0/0", name, flagErr, stableErr);
        end
        if (mode == 0) begin
            checks++;
            if (cycles != 2 + 6 * NumRegs + PcCycles) begin
                failures++;
                $display("FAIL %s_busy_cycles got=%0d required=%0d", name, cycles, 2 + 6 * NumRegs + PcCycles);
            end
        end
        checks++;
        if ({stop_debug, Debug_on, dump_done, tx_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_idle_outputs stop/on/done/valid=%b required 0000", name, {stop_debug, Debug_on, dump_done, tx_valid});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dump_req = 1'b1; tx_ready = 1'b1; dumpReq1 = 1'b0; txReady1 = 1'b1;
        pc_value = 32'h0040_0020;
        for (int k = 0; k < NumRegs; k++) regFile[k] = 32'h1000_0000 + k;
        repeat (2) @(negedge clk);
        checks++;
        if ({Debug_on, stop_debug, tx_valid, busy, dump_done, Debug_read_reg, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs on=%b stop=%b valid=%b busy=%b done=%b idx=%0d data=%h required all 0",
                     Debug_on, stop_debug, tx_valid, busy, dump_done, Debug_read_reg, tx_data);
        end
        checks++;
        if ({dbgOn1, stopDbg1, txValid1, busy1, done1, readReg1, txData1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_n1 got=%h required 0", {dbgOn1, stopDbg1, txValid1, busy1, done1, readReg1, txData1});
        end
        rst = 1'b0; dump_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority busy=%b required 0", busy);
        end
    endtask

    task automatic test_full_dump();
        logic [31:0] firstWord, lastWord;
        run_dump("full", 0, -1, -1);
        checks++;
        if (gotBytes.size() >= 8) begin
            firstWord = {gotBytes[3], gotBytes[2], gotBytes[1], gotBytes[0]};
            lastWord  = {gotBytes[gotBytes.size()-1], gotBytes[gotBytes.size()-2],
                         gotBytes[gotBytes.size()-3], gotBytes[gotBytes.size()-4]};
`ifdef REG_DUMP_PC_EN
            if (firstWord !== 32'h1000_0000 || lastWord !== 32'h0040_0020) begin
`else
            if (firstWord !== 32'h1000_0000 || lastWord !== 32'h1000_001F) begin
`endif
                failures++;
                $display("FAIL full_words first=%h last=%h", firstWord, lastWord);
            end
        end else begin
            failures++;
            $display("FAIL full_words byte_count=%0d required>=8", gotBytes.size());
        end
    endtask

    task automatic test_random_stall();
        randomize_regs();
        run_dump("random_ready", 1, -1, -1);
    endtask

    task automatic test_stall10();
        randomize_regs();
        run_dump("stall10", 2, -1, -1);
    endtask

    task automatic test_req_during_busy();
        randomize_regs();
        run_dump("req_ignored", 0, 40, -1);
    endtask

    task automatic test_back_to_back();
        randomize_regs();
        run_dump("b2b_first", 1, -1, -1);
        randomize_regs();
        run_dump("b2b_second", 0, -1, -1);
    endtask

    task automatic test_abort();
        randomize_regs();
        run_dump("abort", 0, -1, 21);
        run_dump("restart", 1, -1, -1);
    endtask

    task automatic test_single_reg();
        int cycles = 0, idxErr = 0;
        logic [7:0] got1[$];
        logic [31:0] word;
        regFile[0] = $urandom;
        dumpReq1 = 1'b1;
        @(negedge clk);
        dumpReq1 = 1'b0;
        while (busy1 === 1'b1 && cycles < 200) begin
            cycles++;
            if (readReg1 !== 5'd0) idxErr++;
            if (txValid1 === 1'b1) got1.push_back(txData1);
            @(negedge clk);
        end
        checks++;
        if (got1.size() != 4 + PcBytes || cycles != 8 + PcCycles) begin
            failures++;
            $display("FAIL single_len bytes=%0d cycles=%0d required %0d/%0d", got1.size(), cycles, 4 + PcBytes, 8 + PcCycles);
        end
        checks++;
        word = (got1.size() >= 4) ? {got1[3], got1[2], got1[1], got1[0]} : 32'hxxxx_xxxx;
        if (word !== regFile[0]) begin
            failures++;
            $display("FAIL single_word got=%h required=%h", word, regFile[0]);
        end
        checks++;
        if (idxErr != 0) begin
            failures++;
            $display("FAIL single_index nonzero_cycles=%0d required 0", idxErr);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_random_stall();
        test_stall10();
        test_req_during_busy();
        test_back_to_back();
        test_abort();
        test_single_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
